// File: rtl/mdu_pkg.sv
// mdu_pkg
// Shared definitions for the multiply/divide unit: op encodings, the
// control state enum, default latencies and the counter type.
// No ports (package).
package mdu_pkg;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  localparam int MDU_MULT_CYCLES_DEF = 5;
  localparam int MDU_DIV_CYCLES_DEF  = 10;

  localparam int MDU_CNT_W = 16;
  typedef logic [MDU_CNT_W-1:0] mdu_cnt_t;

  typedef enum logic {
    IDLE,
    RUN
  } mdu_state_e;

  // MULT, MULTU, DIV and DIVU occupy the low encodings; everything above
  // DIVU completes (or does nothing) without entering RUN.
  function automatic logic mdu_is_multi_cycle(input logic [2:0] op);
    return (op <= MDU_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith
// Combinational multiply/divide datapath. Produces the {hi, lo} pair for
// MULT/MULTU/DIV/DIVU and a write flag that is low whenever HI/LO must be
// left untouched (divide by zero, or a non-arithmetic op).
// Ports:
//   i_op    : op code (mdu_pkg encoding)
//   i_a     : rs operand (multiplicand / dividend)
//   i_b     : rt operand (multiplier / divisor)
//   o_hi    : product[63:32] or remainder
//   o_lo    : product[31:0] or quotient
//   o_write : result should be committed to HI/LO
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output logic        o_write
);

  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic               w_div_signed;
  logic               w_b_zero;
  logic [31:0]        w_num;
  logic [31:0]        w_den;
  logic [31:0]        w_q_mag;
  logic [31:0]        w_r_mag;
  logic [31:0]        w_q;
  logic [31:0]        w_r;

  assign w_prod_s = 64'($signed(i_a)) * 64'($signed(i_b));
  assign w_prod_u = {32'd0, i_a} * {32'd0, i_b};

  // One unsigned divider serves both DIV and DIVU. For DIV the operands are
  // reduced to magnitudes and the signs reapplied afterwards: the quotient
  // is negative when the signs differ, the remainder follows the dividend.
  // 0x80000000 / -1 falls out naturally: magnitude 2^31 / 1 = 0x80000000,
  // same signs so no negation, remainder 0.
  assign w_div_signed = (i_op == MDU_DIV);
  assign w_b_zero     = (i_b == 32'd0);
  assign w_num        = (w_div_signed && i_a[31]) ? -i_a : i_a;
  // Divisor forced to 1 on zero so the divider never sees x/0; the write
  // flag suppresses the result anyway.
  assign w_den        = w_b_zero ? 32'd1 :
                        ((w_div_signed && i_b[31]) ? -i_b : i_b);
  assign w_q_mag      = w_num / w_den;
  assign w_r_mag      = w_num % w_den;
  assign w_q          = (w_div_signed && (i_a[31] ^ i_b[31])) ? -w_q_mag : w_q_mag;
  assign w_r          = (w_div_signed && i_a[31]) ? -w_r_mag : w_r_mag;

  always_comb begin
    o_hi    = 32'd0;
    o_lo    = 32'd0;
    o_write = 1'b0;
    case (i_op)
      MDU_MULT: begin
        o_hi    = w_prod_s[63:32];
        o_lo    = w_prod_s[31:0];
        o_write = 1'b1;
      end
      MDU_MULTU: begin
        o_hi    = w_prod_u[63:32];
        o_lo    = w_prod_u[31:0];
        o_write = 1'b1;
      end
      MDU_DIV, MDU_DIVU: begin
        o_hi    = w_r;
        o_lo    = w_q;
        o_write = !w_b_zero;
      end
      default: begin
        o_hi    = 32'd0;
        o_lo    = 32'd0;
        o_write = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
// Execute-stage multiply/divide unit owning the architectural HI/LO
// registers. MULT/MULTU/DIV/DIVU compute their result at issue, hold it in
// pending registers and commit it after a fixed latency while busy is high.
// MTHI/MTLO write HI/LO directly when the unit is idle.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : asynchronous active-high reset
//   start : issue op this cycle (ignored while busy)
//   op    : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   a     : rs operand
//   b     : rt operand
//   busy  : multi-cycle operation in flight
//   hi    : architectural HI
//   lo    : architectural LO
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  mdu_state_e  r_state;
  mdu_state_e  w_next_state;
  mdu_cnt_t    r_count;
  mdu_cnt_t    w_latency;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic        r_pend_we;
  logic [31:0] w_arith_hi;
  logic [31:0] w_arith_lo;
  logic        w_arith_write;
  logic        w_accept;
  logic        w_issue_multi;
  logic        w_done;

  mdu_arith u_arith (
    .i_op    (op),
    .i_a     (a),
    .i_b     (b),
    .o_hi    (w_arith_hi),
    .o_lo    (w_arith_lo),
    .o_write (w_arith_write)
  );

  assign w_accept      = start && (r_state == IDLE);
  assign w_issue_multi = w_accept && mdu_is_multi_cycle(op);
  assign w_latency     = (op == MDU_MULT || op == MDU_MULTU) ?
                         mdu_cnt_t'(MULT_CYCLES) : mdu_cnt_t'(DIV_CYCLES);
  // The counter is loaded with N on the issue edge; the N-th RUN edge is the
  // one that takes it from 1 to 0, which is where the result commits.
  assign w_done        = (r_state == RUN) && (r_count == mdu_cnt_t'(1));
  assign busy          = (r_state == RUN);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_issue_multi) w_next_state = RUN;
      RUN:     if (w_done)        w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operands are consumed only on the issue edge; the pending registers
  // isolate the result from later changes on a/b.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count   <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_we <= 1'b0;
    end else if (w_issue_multi) begin
      r_count   <= w_latency;
      r_pend_hi <= w_arith_hi;
      r_pend_lo <= w_arith_lo;
      r_pend_we <= w_arith_write;
    end else if (r_state == RUN) begin
      r_count   <= r_count - mdu_cnt_t'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (w_done) begin
      if (r_pend_we) begin
        hi <= r_pend_hi;
        lo <= r_pend_lo;
      end
    end else if (w_accept) begin
      if (op == MDU_MTHI) hi <= a;
      if (op == MDU_MTLO) lo <= a;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
// Self-checking bench for mult_div_unit: directed scenarios followed by a
// randomized sequence, all compared against a 64-bit arithmetic model of
// HI/LO and the per-op busy latency.
module tb_mult_div_unit;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  // One comparison point: counts it, and on a miss counts the failure and
  // reports the tag with observed and expected values.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Number of busy cycles each op should produce.
  function automatic int latencyOf(input logic [2:0] o);
    case (o)
      3'd0, 3'd1: return MULT_LAT;
      3'd2, 3'd3: return DIV_LAT;
      default:    return 0;
    endcase
  endfunction

  // Architectural HI/LO after an op, computed with plain 64-bit arithmetic.
  // Signed division of sign-extended 64-bit values truncates toward zero and
  // gives the remainder the dividend's sign, and -2^31 / -1 = 2^31 whose
  // low word is 0x80000000, so no special cases are needed beyond b == 0.
  function automatic void modelOp(input logic [2:0] o, input logic [31:0] x,
                                  input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    case (o)
      3'd0: begin p = 64'(sx * sy); mHi = p[63:32]; mLo = p[31:0]; end
      3'd1: begin p = {32'd0, x} * {32'd0, y}; mHi = p[63:32]; mLo = p[31:0]; end
      3'd2: if (y != 0) begin
        q = sx / sy;
        r = sx % sy;
        mLo = q[31:0];
        mHi = r[31:0];
      end
      3'd3: if (y != 0) begin
        mLo = x / y;
        mHi = x % y;
      end
      3'd4: mHi = x;
      3'd5: mLo = x;
      default: ;
    endcase
  endfunction

  // Drives one issue cycle (caller is at a falling edge), then scrambles the
  // operand buses right after the edge so late changes would show up.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x,
                               input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
    op    = 3'($urandom_range(0, 7));
    a     = $urandom;
    b     = $urandom;
  endtask

  // Issues an op and follows it to completion: busy high and HI/LO held for
  // the op's latency, then busy low with the model's HI/LO. Ends on the
  // falling edge of the first idle cycle, so a following call is back-to-back.
  task automatic doOp(input string name, input logic [2:0] o,
                      input logic [31:0] x, input logic [31:0] y);
    logic [31:0] oldHi;
    logic [31:0] oldLo;
    int n;
    oldHi = mHi;
    oldLo = mLo;
    n = latencyOf(o);
    applyStimulus(o, x, y);
    modelOp(o, x, y);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput({name, ".busy"}, {31'd0, busy}, 32'd1);
      checkOutput({name, ".hiHold"}, hi, oldHi);
      checkOutput({name, ".loHold"}, lo, oldLo);
    end
    @(negedge clk);
    checkOutput({name, ".idle"}, {31'd0, busy}, 32'd0);
    checkOutput({name, ".hi"}, hi, mHi);
    checkOutput({name, ".lo"}, lo, mLo);
  endtask

  // Directed scenarios first, then a randomized stream of back-to-back ops.
  initial begin
    logic [2:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;
    logic [31:0] oldHi;
    logic [31:0] oldLo;

    reset = 1'b1;
    start = 1'b0;
    op    = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    #12;
    checkOutput("reset.busy", {31'd0, busy}, 32'd0);
    checkOutput("reset.hi", hi, 32'd0);
    checkOutput("reset.lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    doOp("mult", 3'd0, 32'hFFFFFFFE, 32'd3);
    checkOutput("multHiConst", hi, 32'hFFFFFFFF);
    checkOutput("multLoConst", lo, 32'hFFFFFFFA);

    doOp("multu", 3'd1, 32'hFFFFFFFF, 32'd2);
    checkOutput("multuHiConst", hi, 32'h00000001);
    checkOutput("multuLoConst", lo, 32'hFFFFFFFE);

    doOp("div", 3'd2, 32'hFFFFFFF9, 32'd2);
    checkOutput("divHiConst", hi, 32'hFFFFFFFF);
    checkOutput("divLoConst", lo, 32'hFFFFFFFD);

    doOp("divu0", 3'd3, 32'd7, 32'd0);
    checkOutput("divu0HiConst", hi, 32'hFFFFFFFF);
    checkOutput("divu0LoConst", lo, 32'hFFFFFFFD);

    @(negedge clk);
    doOp("mthi", 3'd4, 32'h12345678, 32'd0);
    checkOutput("mthiConst", hi, 32'h12345678);

    // MTLO issued two cycles into a DIV must be ignored.
    oldHi = mHi;
    oldLo = mLo;
    applyStimulus(3'd2, 32'd100, 32'hFFFFFFFD);
    modelOp(3'd2, 32'd100, 32'hFFFFFFFD);
    for (int i = 0; i < DIV_LAT; i++) begin
      @(negedge clk);
      if (i == 1) begin
        start = 1'b1;
        op    = 3'd5;
        a     = 32'h12345678;
      end else if (i == 2) begin
        start = 1'b0;
      end
      checkOutput("divMtlo.busy", {31'd0, busy}, 32'd1);
      checkOutput("divMtlo.hiHold", hi, oldHi);
      checkOutput("divMtlo.loHold", lo, oldLo);
    end
    @(negedge clk);
    checkOutput("divMtlo.idle", {31'd0, busy}, 32'd0);
    checkOutput("divMtlo.hi", hi, 32'd1);
    checkOutput("divMtlo.lo", lo, 32'hFFFFFFDF);

    doOp("divOvf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
    checkOutput("divOvfHiConst", hi, 32'd0);
    checkOutput("divOvfLoConst", lo, 32'h80000000);

    doOp("nop6", 3'd6, 32'hDEADBEEF, 32'hCAFEF00D);
    doOp("nop7", 3'd7, 32'hA5A5A5A5, 32'h5A5A5A5A);

    // Reset on the third busy cycle of a MULT clears everything at once.
    applyStimulus(3'd0, 32'd1234, 32'd5678);
    repeat (2) begin
      @(negedge clk);
      checkOutput("rstRun.busy", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("rstRun.busyDrop", {31'd0, busy}, 32'd0);
    checkOutput("rstRun.hi", hi, 32'd0);
    checkOutput("rstRun.lo", lo, 32'd0);
    mHi = 32'd0;
    mLo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin
      @(negedge clk);
      checkOutput("rstRun.noCommitBusy", {31'd0, busy}, 32'd0);
      checkOutput("rstRun.noCommitHi", hi, 32'd0);
      checkOutput("rstRun.noCommitLo", lo, 32'd0);
    end

    doOp("b2bMultu", 3'd1, 32'd3, 32'd4);
    checkOutput("b2bMultuHi", hi, 32'd0);
    checkOutput("b2bMultuLo", lo, 32'd12);
    doOp("b2bDivu", 3'd3, 32'd100, 32'd7);
    checkOutput("b2bDivuHi", hi, 32'd2);
    checkOutput("b2bDivuLo", lo, 32'd14);

    // Randomized stream, mixing zero, small and full-range divisors.
    for (int k = 0; k < 30; k++) begin
      rOp = 3'($urandom_range(0, 7));
      rA  = $urandom;
      case ($urandom_range(0, 5))
        0:       rB = 32'd0;
        1, 2:    rB = $urandom_range(1, 20);
        3:       rB = -($urandom_range(1, 20));
        default: rB = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) rA = $urandom_range(0, 1000);
      doOp("rand", rOp, rA, rB);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
